// File: rtl/mem_arb_pkg.sv
// Shared encodings and widths for the two-requester memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MA_BUSY = 3'd1,
        IF_BUSY = 3'd2,
        MA_DONE = 3'd3,
        IF_DONE = 3'd4
    } arb_state_e;

    function automatic logic is_busy(input arb_state_e s);
        return (s == MA_BUSY) || (s == IF_BUSY);
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Counts BUSY cycles from 1 and flags expiry once the count reaches TIMEOUT.
module mem_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // clear is raised on the edge that enters BUSY, so the first BUSY cycle reads 1
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = CW'(1);
        end else if (enable && !expire) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = enable && (cnt_q == CW'(TIMEOUT));

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one backing memory between fetch and memory-access stages.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_delay,
    input  logic              ma_le,
    input  logic              ma_we,
    input  logic [ADDR_W-1:0] ma_addr,
    input  logic [DATA_W-1:0] ma_wdata,
    output logic [DATA_W-1:0] ma_rdata,
    output logic              ma_delay,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              timeout_err
);

    arb_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] ma_rdata_q;
    logic              terr_q;

    logic ma_any;
    logic busy;
    logic wd_clear;
    logic wd_expire;

    assign ma_any   = ma_le | ma_we;
    assign busy     = is_busy(state_q);
    assign wd_clear = (state_q == IDLE) && (ma_any || if_req);

    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (busy),
        .expire (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            ma_rdata_q <= '0;
            terr_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ma_any) begin
                        state_q <= MA_BUSY;
                        addr_q  <= ma_addr;
                        we_q    <= ma_we;
                        wdata_q <= ma_we ? ma_wdata : '0;
                    end else if (if_req) begin
                        state_q <= IF_BUSY;
                        addr_q  <= if_addr;
                        we_q    <= 1'b0;
                        wdata_q <= '0;
                    end
                end
                MA_BUSY: begin
                    if (mem_ack) begin
                        ma_rdata_q <= we_q ? '0 : mem_rdata;
                        state_q    <= MA_DONE;
                    end else if (wd_expire) begin
                        ma_rdata_q <= '0;
                        terr_q     <= 1'b1;
                        state_q    <= MA_DONE;
                    end
                end
                IF_BUSY: begin
                    if (mem_ack) begin
                        if_rdata_q <= mem_rdata;
                        state_q    <= IF_DONE;
                    end else if (wd_expire) begin
                        if_rdata_q <= '0;
                        terr_q     <= 1'b1;
                        state_q    <= IF_DONE;
                    end
                end
                MA_DONE, IF_DONE: state_q <= IDLE;
                default:          state_q <= IDLE;
            endcase
        end
    end

    // Outputs seen by the pipeline are gated by reset so stage registers reset cleanly
    assign mem_req     = !reset && busy;
    assign mem_we      = !reset && (state_q == MA_BUSY) && we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = mem_we ? wdata_q : '0;
    assign ma_delay    = !reset && ma_any && (state_q != MA_DONE);
    assign if_delay    = !reset && if_req && (state_q != IF_DONE);
    assign if_rdata    = if_rdata_q;
    assign ma_rdata    = ma_rdata_q;
    assign timeout_err = terr_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum BUSY cycles to wait for mem_ack before abort.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 if_req  input  1  instruction-fetch read request.
REQ-005 if_addr  input  16  fetch word address.
REQ-006 if_rdata  output  32  registered fetch data.
REQ-007 if_delay  output  1  stall to fetch stage.
REQ-008 ma_le  input  1  memory-access-stage load request.
REQ-009 ma_we  input  1  memory-access-stage store request.
REQ-010 ma_addr  input  16  data word address.
REQ-011 ma_wdata  input  32  store data.
REQ-012 ma_rdata  output  32  registered load data.
REQ-013 ma_delay  output  1  stall to memory-access stage.
REQ-014 mem_req, mem_we  output  1 each  backing-memory request and write enable.
REQ-015 mem_addr  output  16 ; mem_wdata  output  32  backing-memory address and write data.
REQ-016 mem_rdata  input  32 ; mem_ack  input  1  memory read data and one-cycle completion pulse.
REQ-017 timeout_err  output  1  sticky abort flag.

Function
REQ-018 The FSM SHALL have states IDLE, MA_BUSY, IF_BUSY, MA_DONE, IF_DONE.
REQ-019 IDLE SHALL go to MA_BUSY if ma_le|ma_we, else to IF_BUSY if if_req, else stay; the MA stage has fixed priority.
REQ-020 On leaving IDLE, the granted address, write flag and write data SHALL be captured; ma_we with ma_le SHALL be treated as a store.
REQ-021 mem_req SHALL be 1 exactly in the BUSY states, with mem_addr/mem_we/mem_wdata driven from captured registers and held stable.
REQ-022 mem_we and mem_wdata SHALL be 0 in all states except MA_BUSY with a captured store.
REQ-023 In x_BUSY, mem_ack SHALL load mem_rdata into x_rdata (0 for a store) and move to x_DONE.
REQ-024 x_DONE SHALL last one cycle, then return to IDLE; no new grant is issued from a DONE state.
REQ-025 ma_delay SHALL equal (ma_le|ma_we) and not MA_DONE; if_delay SHALL equal if_req and not IF_DONE (combinational).
REQ-026 Minimum latency: request in IDLE cycle N, mem_req N+1, ack N+1, delay low with valid rdata N+2, IDLE N+3.
REQ-027 With both requesters pending, if_delay SHALL stay high through the whole MA transaction and its own.
REQ-028 A watchdog SHALL count BUSY cycles from 1; if count reaches TIMEOUT with no ack, the FSM SHALL go to x_DONE with x_rdata=0 and set timeout_err.
REQ-029 The watchdog SHALL clear on every entry to a BUSY state.
REQ-030 mem_ack outside the BUSY states SHALL be ignored.
REQ-031 A request dropped mid-transaction SHALL still complete; its DONE result is discarded.
REQ-032 x_rdata SHALL hold its value until the next completion for that requester.

Reset
REQ-033 Reset SHALL force IDLE, watchdog=0, if_rdata=ma_rdata=0, timeout_err=0 and the capture registers to 0 on the next edge, including mid-BUSY.
REQ-034 While reset is high, mem_req, mem_we, if_delay and ma_delay SHALL be 0, so downstream stage registers accept their own reset.

Structure
REQ-035 Package mem_arb_pkg SHALL hold state encodings, ADDR_W=16, DATA_W=32 and the TIMEOUT default.
REQ-036 The watchdog SHALL be sub-module mem_arb_watchdog (clear, enable, expire); all other logic is flat.

Verification
REQ-037 Reset, then ma_le=1, ma_addr=0x0010, memory acks on first BUSY cycle with 0xDEADBEEF -> ma_delay high 2 cycles, ma_rdata=0xDEADBEEF with ma_delay low in the third.
REQ-038 ma_we=1, ma_addr=0x0020, ma_wdata=0x12345678 -> mem_we=1, mem_addr=0x0020, mem_wdata=0x12345678 while mem_req; ma_rdata=0 at completion.
REQ-039 if_req and ma_le raised together, ack latency 3 each -> MA served first; if_delay high until IF_DONE, 11 cycles after request.
REQ-040 TIMEOUT=4, never ack -> mem_req high exactly 4 cycles, ma_rdata=0, timeout_err=1 until reset.
REQ-041 Reset asserted in second MA_BUSY cycle -> mem_req and both delays 0 that cycle, IDLE next edge, and a late mem_ack leaves ma_rdata at 0.
